sram_like_arbiter: RTL and testbench
====================================

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, number of sram-like master channels; legal range 2..4.
REQ-002 Parameter DEPTH, default 4, maximum outstanding accepted requests; power of 2, 2..16.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 m_req  in  NUM_CH  per-channel request; channel i is bit i.
REQ-007 m_wr  in  NUM_CH  per-channel write flag.
REQ-008 m_size  in  2*NUM_CH  per-channel size; channel i is bits [2i+1:2i].
REQ-009 m_wstrb  in  4*NUM_CH  per-channel byte strobes.
REQ-010 m_addr  in  32*NUM_CH  per-channel address.
REQ-011 m_wdata  in  32*NUM_CH  per-channel write data.
REQ-012 m_addr_ok  out  NUM_CH  per-channel request accepted.
REQ-013 m_data_ok  out  NUM_CH  per-channel response valid.
REQ-014 m_rdata  out  32  shared read data; valid for the channel whose m_data_ok is set.
REQ-015 s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata  out  1/1/2/4/32/32  slave-side request.
REQ-016 s_addr_ok, s_data_ok  in  1  slave handshakes; s_rdata  in  32  slave read data.
REQ-017 outstanding  out  $clog2(DEPTH)+1  current count of accepted, unanswered requests.
REQ-018 resp_err  out  1  sticky flag: s_data_ok received with no outstanding request.

Function
REQ-019 Request handshake SHALL be s_req & s_addr_ok in the same cycle; response SHALL be s_data_ok.
REQ-020 s_req SHALL equal (|m_req) & ~full, where full means outstanding == DEPTH; pops in the same cycle do not lift full (no bypass).
REQ-021 Arbiter states: IDLE (no lock) and LOCK (grant held); IDLE -> LOCK when s_req=1 and s_addr_ok=0; LOCK -> IDLE on handshake.
REQ-022 In LOCK, the grant SHALL stay on the locked channel regardless of other m_req bits.
REQ-023 In IDLE, the grant SHALL go to the selected requesting channel (REQ-035/036) combinationally in the same cycle.
REQ-024 s_wr/s_size/s_wstrb/s_addr/s_wdata SHALL be muxed from the granted channel; they are zero when s_req=0.
REQ-025 m_addr_ok[g] SHALL be asserted only for granted channel g, and only on the handshake cycle; all other bits are 0.
REQ-026 On handshake, the granted channel id SHALL be pushed into a DEPTH-entry in-order ID FIFO.
REQ-027 On s_data_ok with a non-empty FIFO, the head entry SHALL be popped and m_data_ok[head] asserted in the same cycle; m_rdata SHALL equal s_rdata (zero latency).
REQ-028 On s_data_ok with an empty FIFO, the FIFO SHALL be unchanged, no m_data_ok bit set, and resp_err set.
REQ-029 Push and pop in the same cycle SHALL leave outstanding unchanged and update both pointers.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH; outstanding counts 0..DEPTH exactly.
REQ-031 Responses SHALL return to channels in exact acceptance order.

Reset
REQ-032 On reset: FIFO empty, outstanding=0, state IDLE, round-robin pointer=0, resp_err=0.
REQ-033 During and in the cycle after reset, s_req, m_addr_ok and m_data_ok SHALL be 0; in-flight requests are discarded.
REQ-034 Reset asserted mid-LOCK SHALL return to IDLE with no handshake recorded.

Configuration
REQ-035 Macro SRAM_ARB_RR_EN defined: round-robin; search starts at pointer; after each handshake the pointer becomes (granted+1) mod NUM_CH.
REQ-036 Macro SRAM_ARB_RR_EN undefined: fixed priority, lowest requesting index wins; no pointer register exists.

Verification
REQ-037 NUM_CH=2; both m_req=1, s_addr_ok=1 for 4 cycles; RR -> grants 0,1,0,1; fixed -> 0,0,0,0.
REQ-038 ch1 requests with addr 0x1C00_0010, s_addr_ok=0 for 3 cycles; ch0 raises m_req in cycle 2 -> s_addr stays 0x1C00_0010; m_addr_ok=2'b10 on the accept cycle.
REQ-039 DEPTH=4; 4 accepts, no s_data_ok -> outstanding=4, s_req=0; one s_data_ok -> m_data_ok asserted for first channel, s_req=1 in the next cycle.
REQ-040 Accepts ch0, ch1, ch0; three s_data_ok with rdata 0xA, 0xB, 0xC -> m_data_ok order 01,10,01; m_rdata 0xA, 0xB, 0xC.
REQ-041 s_data_ok while outstanding=0 -> m_data_ok=0, resp_err=1 held until reset.
REQ-042 Reset asserted with outstanding=3 in LOCK -> next cycle outstanding=0, IDLE, all handshake outputs 0.

Source files
------------

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// sram_like_arbiter: NUM_CH sram-like masters onto one slave, in-order response routing.
// SRAM_ARB_RR_EN selects round-robin arbitration; fixed priority otherwise. Rev 1.0
module sram_like_arbiter #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        m_req_i,
  input  logic [NUM_CH-1:0]        m_wr_i,
  input  logic [2*NUM_CH-1:0]      m_size_i,
  input  logic [4*NUM_CH-1:0]      m_wstrb_i,
  input  logic [32*NUM_CH-1:0]     m_addr_i,
  input  logic [32*NUM_CH-1:0]     m_wdata_i,
  output logic [NUM_CH-1:0]        m_addr_ok_o,
  output logic [NUM_CH-1:0]        m_data_ok_o,
  output logic [31:0]              m_rdata_o,
  output logic                     s_req_o,
  output logic                     s_wr_o,
  output logic [1:0]               s_size_o,
  output logic [3:0]               s_wstrb_o,
  output logic [31:0]              s_addr_o,
  output logic [31:0]              s_wdata_o,
  input  logic                     s_addr_ok_i,
  input  logic                     s_data_ok_i,
  input  logic [31:0]              s_rdata_i,
  output logic [$clog2(DEPTH):0]   outstanding_o,
  output logic                     resp_err_o
);
  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t        state_q;
  logic [CW-1:0] lock_ch_q;
  logic [CW-1:0] sel_ch;
  logic [CW-1:0] grant;
  logic [CW-1:0] fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          err_q;
  logic          rst_hold_q;
  logic          blank, full, s_req, hs, pop;

  // Outputs stay quiet during reset and for one cycle after it.
  assign blank = reset | rst_hold_q;
  assign full  = (cnt_q == CNT_FULL);
  assign s_req = ~blank & (|m_req_i) & ~full;
  assign grant = (state_q == LOCK) ? lock_ch_q : sel_ch;
  assign hs    = s_req & s_addr_ok_i;
  assign pop   = ~blank & s_data_ok_i & (cnt_q != '0);

`ifdef SRAM_ARB_RR_EN
  logic [CW-1:0] rr_ptr_q;

  always_comb begin
    int idx;
    sel_ch = rr_ptr_q;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_CH;
      if (m_req_i[idx]) sel_ch = CW'(idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else if (hs) rr_ptr_q <= (grant == CW'(NUM_CH - 1)) ? '0 : grant + CW'(1);
  end
`else
  always_comb begin
    sel_ch = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (m_req_i[k]) sel_ch = CW'(k);
    end
  end
`endif

  always_ff @(posedge clk) begin
    rst_hold_q <= reset;
    if (reset) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (s_req && !s_addr_ok_i) begin
          state_q   <= LOCK;
          lock_ch_q <= sel_ch;
        end
        LOCK: if (hs) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (hs)  wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({hs, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
      if (~blank && s_data_ok_i && cnt_q == '0) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (hs) fifo_q[wr_ptr_q] <= grant;
  end

  always_comb begin
    int gi;
    gi          = int'(grant);
    s_req_o     = s_req;
    s_wr_o      = 1'b0;
    s_size_o    = '0;
    s_wstrb_o   = '0;
    s_addr_o    = '0;
    s_wdata_o   = '0;
    m_addr_ok_o = '0;
    m_data_ok_o = '0;
    if (s_req) begin
      s_wr_o    = m_wr_i[gi];
      s_size_o  = m_size_i[gi*2 +: 2];
      s_wstrb_o = m_wstrb_i[gi*4 +: 4];
      s_addr_o  = m_addr_i[gi*32 +: 32];
      s_wdata_o = m_wdata_i[gi*32 +: 32];
    end
    if (hs)  m_addr_ok_o[grant] = 1'b1;
    if (pop) m_data_ok_o[fifo_q[rd_ptr_q]] = 1'b1;
  end

  assign m_rdata_o     = s_rdata_i;
  assign outstanding_o = cnt_q;
  assign resp_err_o    = err_q;
endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// tb_sram_like_arbiter: directed scoreboard bench for sram_like_arbiter (NUM_CH=2, DEPTH=4).
module tb_sram_like_arbiter;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m_req, m_wr, m_addr_ok, m_data_ok;
  logic [3:0]  m_size;
  logic [7:0]  m_wstrb;
  logic [63:0] m_addr, m_wdata;
  logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
  logic        s_req, s_wr, s_addr_ok, s_data_ok, resp_err;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [2:0]  outstanding;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  sram_like_arbiter #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .m_req_i(m_req), .m_wr_i(m_wr), .m_size_i(m_size), .m_wstrb_i(m_wstrb),
    .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_addr_ok_o(m_addr_ok), .m_data_ok_o(m_data_ok), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_wr_o(s_wr), .s_size_o(s_size), .s_wstrb_o(s_wstrb),
    .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_addr_ok_i(s_addr_ok), .s_data_ok_i(s_data_ok), .s_rdata_i(s_rdata),
    .outstanding_o(outstanding), .resp_err_o(resp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic accept(input logic [1:0] req, input int g);
    m_req = req;
    s_addr_ok = 1'b1;
    settle();
    chk("accept_addr_ok", m_addr_ok, 64'(2'b01 << g));
    exp_q.push_back(g);
    step();
    m_req = 2'b00;
    s_addr_ok = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rd);
    int e;
    s_data_ok = 1'b1;
    s_rdata = rd;
    settle();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    chk("resp_data_ok", m_data_ok, 64'(2'b01 << e));
    chk("resp_rdata", m_rdata, rd);
    step();
    s_data_ok = 1'b0;
  endtask

  initial begin
    int g;
    reset = 1'b1;
    m_req = 2'b11; m_wr = '0; m_size = '0; m_wstrb = '0;
    m_addr = {32'h0000_0200, 32'h0000_0100}; m_wdata = '0;
    s_addr_ok = 1'b1; s_data_ok = 1'b0; s_rdata = '0;
    step();
    settle();
    chk("rst_s_req", s_req, 0);
    chk("rst_addr_ok", m_addr_ok, 0);
    step();
    reset = 1'b0;
    settle();
    chk("post_rst_s_req", s_req, 0);
    chk("post_rst_addr_ok", m_addr_ok, 0);
    chk("post_rst_outstanding", outstanding, 0);
    chk("post_rst_resp_err", resp_err, 0);
    step();

    // Both channels request continuously until the FIFO fills.
    for (int i = 0; i < 4; i++) begin
      settle();
      g = RR ? (i % 2) : 0;
      chk("arb_grant", m_addr_ok, 64'(2'b01 << g));
      chk("arb_s_addr", s_addr, (g == 1) ? 32'h200 : 32'h100);
      exp_q.push_back(g);
      step();
    end
    settle();
    chk("full_outstanding", outstanding, 4);
    chk("full_s_req", s_req, 0);
    s_data_ok = 1'b1;
    s_rdata = 32'h11;
    settle();
    chk("full_no_bypass", s_req, 0);
    g = exp_q.pop_front();
    chk("full_pop_data_ok", m_data_ok, 64'(2'b01 << g));
    step();
    s_data_ok = 1'b0;
    settle();
    chk("unfull_s_req", s_req, 1);
    chk("unfull_grant", m_addr_ok, 2'b01);
    exp_q.push_back(0);
    step();
    m_req = 2'b00;
    s_addr_ok = 1'b0;
    for (int k = 0; k < 4; k++) respond(32'h20 + 32'(k));
    settle();
    chk("drain_outstanding", outstanding, 0);

    // Lock on ch1 while ch0 joins.
    m_req = 2'b10; m_addr[63:32] = 32'h1C00_0010; m_wr = 2'b10;
    m_wdata[63:32] = 32'hDEAD_BEEF; m_wstrb[7:4] = 4'hF; m_size[3:2] = 2'b10;
    settle();
    chk("lock_s_req", s_req, 1);
    chk("lock_s_addr0", s_addr, 32'h1C00_0010);
    chk("lock_addr_ok0", m_addr_ok, 0);
    step();
    m_req = 2'b11; m_addr[31:0] = 32'h0000_1234;
    settle();
    chk("lock_s_addr1", s_addr, 32'h1C00_0010);
    chk("lock_addr_ok1", m_addr_ok, 0);
    step();
    settle();
    chk("lock_s_addr2", s_addr, 32'h1C00_0010);
    step();
    s_addr_ok = 1'b1;
    settle();
    chk("lock_accept", m_addr_ok, 2'b10);
    chk("lock_s_wr", s_wr, 1);
    chk("lock_s_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("lock_s_wstrb", s_wstrb, 4'hF);
    chk("lock_s_size", s_size, 2'b10);
    exp_q.push_back(1);
    step();
    m_req = 2'b00; s_addr_ok = 1'b0;
    settle();
    chk("idle_s_req", s_req, 0);
    chk("idle_s_addr_zero", s_addr, 0);
    respond(32'h55);

    // Ordered responses, including one simultaneous push and pop.
    accept(2'b01, 0);
    accept(2'b10, 1);
    accept(2'b01, 0);
    m_req = 2'b10; s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'hA;
    settle();
    chk("pushpop_addr_ok", m_addr_ok, 2'b10);
    g = exp_q.pop_front();
    chk("pushpop_data_ok", m_data_ok, 64'(2'b01 << g));
    chk("pushpop_rdata", m_rdata, 32'hA);
    exp_q.push_back(1);
    step();
    m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    settle();
    chk("pushpop_outstanding", outstanding, 3);
    respond(32'hB);
    respond(32'hC);
    respond(32'hD);
    settle();
    chk("order_outstanding", outstanding, 0);

    // Spurious response sets the sticky error.
    s_data_ok = 1'b1;
    settle();
    chk("spurious_data_ok", m_data_ok, 0);
    step();
    s_data_ok = 1'b0;
    settle();
    chk("spurious_resp_err", resp_err, 1);
    chk("spurious_outstanding", outstanding, 0);
    step();
    step();
    settle();
    chk("sticky_resp_err", resp_err, 1);

    // Reset mid-LOCK with three outstanding.
    accept(2'b01, 0);
    accept(2'b01, 0);
    accept(2'b01, 0);
    m_req = 2'b10; s_addr_ok = 1'b0;
    settle();
    chk("prelock_s_req", s_req, 1);
    step();
    settle();
    chk("prereset_outstanding", outstanding, 3);
    reset = 1'b1; m_req = 2'b11; s_addr_ok = 1'b1;
    settle();
    chk("midrst_s_req", s_req, 0);
    chk("midrst_addr_ok", m_addr_ok, 0);
    step();
    reset = 1'b0; s_data_ok = 1'b1;
    settle();
    chk("rst2_outstanding", outstanding, 0);
    chk("rst2_resp_err", resp_err, 0);
    chk("rst2_s_req", s_req, 0);
    chk("rst2_data_ok", m_data_ok, 0);
    step();
    exp_q.delete();
    s_data_ok = 1'b0; m_req = 2'b01; s_addr_ok = 1'b1;
    settle();
    chk("rst2_idle_grant", m_addr_ok, 2'b01);
    chk("rst2_resp_err_hold", resp_err, 0);
    step();
    m_req = 2'b00; s_addr_ok = 1'b0;
    settle();
    chk("rst2_outstanding_after", outstanding, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
